// File: rtl/rank_sort_pipe.sv
// rank_sort_pipe: pipelined odd-even transposition sorter with a valid/ready stream.
// The block sorts N samples of W bits per transaction. It also reports one selected
// rank, chosen by a tag that travels alongside the data.
module rank_sort_pipe #(
    parameter int W    = 8,
    parameter int N    = 9,
    parameter int DESC = 0,
    parameter int RW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [RW-1:0]   rank_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [W-1:0]    out_rank,
    output logic            busy
);

    // One compare-exchange layer. Pairs start at lane 0 on even stages and at
    // lane 1 on odd stages. An unpaired end lane passes through, and equal
    // values never swap, so the sort is stable.
    function automatic logic [N*W-1:0] cx_stage(input logic [N*W-1:0] d, input int odd);
        logic [N*W-1:0] r;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sw;
        r = d;
        for (int j = 0; j < N - 1; j++) begin
            if ((j % 2) == odd) begin
                a  = d[j*W +: W];
                b  = d[(j+1)*W +: W];
                sw = (DESC != 0) ? (a < b) : (a > b);
                if (sw) begin
                    r[j*W +: W]     = b;
                    r[(j+1)*W +: W] = a;
                end
            end
        end
        return r;
    endfunction

    logic [N*W-1:0] r_data [N];
    logic [RW-1:0]  r_tag  [N];
    logic [N-1:0]   r_vld;

    logic [N*W-1:0] w_cx   [N];
    logic           w_advance;
    logic [RW-1:0]  w_slot;

    // Exchange network feeding each stage register: stage 0 sorts the raw
    // input, and each later stage works on the previous register.
    for (genvar s = 0; s < N; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_cx[s] = cx_stage(in_data, 0);
        end else begin : g_rest
            assign w_cx[s] = cx_stage(r_data[s-1], s % 2);
        end
    end

    // The whole pipe moves as one unit. It freezes only while a valid output is refused.
    assign w_advance = !(r_vld[N-1] && !out_ready);

    // Stage registers: every stage shifts on advance and holds otherwise. Bubbles are kept, not collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < N; s++) begin
                r_data[s] <= '0;
                r_tag[s]  <= '0;
            end
        end else if (w_advance) begin
            r_vld[0]  <= in_valid;
            r_data[0] <= w_cx[0];
            r_tag[0]  <= rank_sel;
            for (int s = 1; s < N; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_data[s] <= w_cx[s];
                r_tag[s]  <= r_tag[s-1];
            end
        end
    end

    // Rank tags wider than the window report the last slot.
    always_comb begin
        w_slot = r_tag[N-1];
        if (int'(r_tag[N-1]) > N - 1) begin
            w_slot = RW'(N - 1);
        end
    end

    assign out_data  = r_data[N-1];
    assign out_rank  = r_data[N-1][int'(w_slot)*W +: W];
    assign out_valid = r_vld[N-1];
    assign in_ready  = w_advance;
    assign busy      = |r_vld;

endmodule

// File: tb/tb_rank_sort_pipe.sv
// Scoreboard bench for rank_sort_pipe. The main instance uses W=8, N=9. A small
// instance uses N=2, W=1, and a wide instance uses N=16, W=12 with descending order.
module tb_rank_sort_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- main instance: W=8, N=9 ----------------
    logic        rst_n = 1'b0;
    logic        m_in_valid = 1'b0;
    logic        m_in_ready;
    logic [71:0] m_in_data = '0;
    logic [3:0]  m_rank_sel = '0;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [71:0] m_out_data;
    logic [7:0]  m_out_rank;
    logic        m_busy;

    rank_sort_pipe #(.W(8), .N(9), .DESC(0)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_data(m_in_data), .rank_sel(m_rank_sel),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_data(m_out_data), .out_rank(m_out_rank), .busy(m_busy)
    );

    // ---------------- small instance: W=1, N=2 ----------------
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [1:0] s_in_data = '0;
    logic [0:0] s_rank_sel = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [1:0] s_out_data;
    logic [0:0] s_out_rank;
    logic       s_busy;

    rank_sort_pipe #(.W(1), .N(2), .DESC(0)) u_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .rank_sel(s_rank_sel),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_rank(s_out_rank), .busy(s_busy)
    );

    // ---------------- wide instance: W=12, N=16, descending ----------------
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [191:0] b_in_data = '0;
    logic [3:0]   b_rank_sel = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b1;
    logic [191:0] b_out_data;
    logic [11:0]  b_out_rank;
    logic         b_busy;

    rank_sort_pipe #(.W(12), .N(16), .DESC(1)) u_big (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .rank_sel(b_rank_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_rank(b_out_rank), .busy(b_busy)
    );

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [191:0] d;
        logic [11:0]  rk;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t m_q[$];
    exp_t s_q[$];
    exp_t b_q[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference sorts (plain bubble sort over the unpacked slots).
    function automatic logic [71:0] ref9(input logic [71:0] d);
        logic [7:0] a[9];
        logic [7:0] t;
        logic [71:0] r;
        for (int i = 0; i < 9; i++) a[i] = d[i*8 +: 8];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    function automatic logic [191:0] ref16d(input logic [191:0] d);
        logic [11:0] a[16];
        logic [11:0] t;
        logic [191:0] r;
        for (int i = 0; i < 16; i++) a[i] = d[i*12 +: 12];
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (a[j] < a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        for (int i = 0; i < 16; i++) r[i*12 +: 12] = a[i];
        return r;
    endfunction

    // ---------------- out_ready driver for the main instance ----------------
    bit rnd_mode = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitors ----------------
    logic        prev_stall = 1'b0;
    logic [71:0] prev_data  = '0;
    logic [7:0]  prev_rank  = '0;

    always @(negedge clk) begin
        exp_t e;
        chk("in_ready_rule", 192'(m_in_ready), 192'(!(m_out_valid && !m_out_ready)));
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_data_stable", 192'(m_out_data), 192'(prev_data));
                chk("stall_rank_stable", 192'(m_out_rank), 192'(prev_rank));
            end
            if (m_out_valid && m_out_ready) begin
                if (m_q.size() == 0) begin
                    chk("main_unexpected_output", 192'(m_out_valid), 192'(0));
                end else begin
                    e = m_q.pop_front();
                    chk("main_data", 192'(m_out_data), e.d);
                    chk("main_rank", 192'(m_out_rank), 192'(e.rk));
                    if (e.lat) chk("main_latency", 192'(cyc - e.cyc), 192'(9));
                end
            end
        end
        prev_stall = m_out_valid && !m_out_ready;
        prev_data  = m_out_data;
        prev_rank  = m_out_rank;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                chk("small_unexpected_output", 192'(s_out_valid), 192'(0));
            end else begin
                e = s_q.pop_front();
                chk("small_data", 192'(s_out_data), e.d);
                chk("small_rank", 192'(s_out_rank), 192'(e.rk));
                chk("small_latency", 192'(cyc - e.cyc), 192'(2));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                chk("big_unexpected_output", 192'(b_out_valid), 192'(0));
            end else begin
                e = b_q.pop_front();
                chk("big_data", b_out_data, e.d);
                chk("big_rank", 192'(b_out_rank), 192'(e.rk));
                chk("big_latency", 192'(cyc - e.cyc), 192'(16));
            end
        end
    end

    // ---------------- stimulus tasks (entered just after a rising edge) ----------------
    task automatic send_m(input logic [71:0] d, input logic [3:0] r,
                          input logic [71:0] ed, input logic [7:0] er, input bit lat);
        exp_t e;
        bit   done = 1'b0;
        m_in_valid = 1'b1;
        m_in_data  = d;
        m_rank_sel = r;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (m_in_ready) begin
                e.d = 192'(ed); e.rk = 12'(er); e.cyc = cyc; e.lat = lat;
                m_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("main_accept_timeout", 192'(0), 192'(1));
        m_in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [1:0] d, input logic [0:0] r,
                          input logic [1:0] ed, input logic [0:0] er);
        exp_t e;
        s_in_valid = 1'b1; s_in_data = d; s_rank_sel = r;
        @(negedge clk);
        if (s_in_ready) begin
            e.d = 192'(ed); e.rk = 12'(er); e.cyc = cyc; e.lat = 1'b1;
            s_q.push_back(e);
        end else begin
            chk("small_in_ready", 192'(s_in_ready), 192'(1));
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [191:0] d, input logic [3:0] r);
        exp_t e;
        b_in_valid = 1'b1; b_in_data = d; b_rank_sel = r;
        @(negedge clk);
        if (b_in_ready) begin
            e.d = ref16d(d); e.rk = e.d[int'(r)*12 +: 12]; e.cyc = cyc; e.lat = 1'b1;
            b_q.push_back(e);
        end else begin
            chk("big_in_ready", 192'(b_in_ready), 192'(1));
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int k = 0;
        while ((m_q.size() + s_q.size() + b_q.size()) != 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        if (k >= limit) chk(name, 192'(m_q.size() + s_q.size() + b_q.size()), 192'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] rnd9();
        logic [71:0] d;
        for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [71:0]  d;
        logic [71:0]  e;
        logic [3:0]   r;
        logic [191:0] bd;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 192'(m_out_valid), 192'(0));
        chk("reset_busy",      192'(m_busy),      192'(0));
        chk("reset_in_ready",  192'(m_in_ready),  192'(1));
        chk("reset_out_data",  192'(m_out_data),  192'(0));
        chk("reset_out_rank",  192'(m_out_rank),  192'(0));
        @(posedge clk);
        #1;

        // Directed window: slots 0..8 = 9,3,7,1,8,2,6,4,5, median requested.
        send_m({8'd5, 8'd4, 8'd6, 8'd2, 8'd8, 8'd1, 8'd7, 8'd3, 8'd9}, 4'd4,
               {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd5, 1'b1);
        drain("drain_directed", 100);

        // Back-to-back streaming with rank cycling min / median / max.
        for (int k = 0; k < 20; k++) begin
            d = rnd9();
            e = ref9(d);
            r = (k % 3 == 0) ? 4'd0 : (k % 3 == 1) ? 4'd4 : 4'd8;
            send_m(d, r, e, e[int'(r)*8 +: 8], 1'b1);
        end
        drain("drain_stream", 100);

        // Edge data.
        send_m({9{8'hAA}}, 4'd4, {9{8'hAA}}, 8'hAA, 1'b1);
        send_m({9{8'h00}}, 4'd0, {9{8'h00}}, 8'h00, 1'b1);
        send_m({9{8'hFF}}, 4'd8, {9{8'hFF}}, 8'hFF, 1'b1);
        send_m({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 4'd15,
               {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'd9, 1'b1);
        drain("drain_edge", 100);

        // Random backpressure.
        rnd_mode = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = rnd9();
            e = ref9(d);
            r = 4'(k % 9);
            send_m(d, r, e, e[int'(r)*8 +: 8], 1'b0);
        end
        drain("drain_backpressure", 1000);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-stream with five transactions in flight.
        for (int k = 0; k < 5; k++) begin
            d = rnd9();
            e = ref9(d);
            send_m(d, 4'd4, e, e[32 +: 8], 1'b1);
        end
        chk("inflight_busy", 192'(m_busy), 192'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 192'(m_out_valid), 192'(0));
        chk("midreset_busy",      192'(m_busy),      192'(0));
        m_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("post_reset_out_valid", 192'(m_out_valid), 192'(0));
        chk("post_reset_busy",      192'(m_busy),      192'(0));
        @(posedge clk);
        #1;

        // N=2, W=1: {1,0} -> {0,1}, and an already-sorted pair.
        send_s(2'b01, 1'b1, 2'b10, 1'b1);
        send_s(2'b10, 1'b0, 2'b10, 1'b0);

        // N=16, W=12, descending.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) bd[i*12 +: 12] = 12'($urandom_range(0, 4095));
            send_b(bd, 4'(k * 7));
        end
        drain("drain_params", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rank_sort_pipe.md
# rank_sort_pipe

Parametrised, fully pipelined sorting network with a valid/ready stream interface. It sorts N samples of W bits per transaction and also returns one selected rank: minimum, median, maximum or any other. It is the next-generation replacement for the fixed 9×8-bit combinational sorter used by the median/rank denoising filters. It sits between the 3×3 (or larger) window builder and the pixel output stage, and sustains one window per clock when not back-pressured.

## Interface
Parameters:
- W, 8, sample width in bits (≥1)
- N, 9, samples per transaction (2..16)
- DESC, 0, 0 = ascending output order, 1 = descending
- RW, $clog2(N), width of rank_sel (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/rank_sel valid this cycle
- in_ready  out  1  block accepts input this cycle
- in_data  in  N*W  sample i at bits [i*W +: W]
- rank_sel  in  RW  rank to report on out_rank; travels with the data
- out_valid  out  1  out_data/out_rank valid
- out_ready  in  1  downstream accepts output
- out_data  out  N*W  sorted samples; slot 0 at bits [W-1:0]
- out_rank  out  W  out_data slot rank_sel (clamped)
- busy  out  1  any pipeline stage holds a valid transaction

## Operation
- Odd-even transposition network of N compare-exchange stages, each followed by a register stage: S0..S(N-1).
- Stage s, s even: compare-exchange pairs (0,1),(2,3),…. Stage s, s odd: pairs (1,2),(3,4),…. An unpaired end lane passes through.
- Compare-exchange, DESC=0: swap only if lane[j] > lane[j+1], unsigned. DESC=1: swap only if lane[j] < lane[j+1]. Equal values never swap.
- Each stage register holds N*W data, an RW-bit rank tag and a valid bit.
- The rank tag is captured from rank_sel at acceptance.
- out_rank = S(N-1) data slot min(tag, N-1). A tag ≥ N reports slot N-1.
- out_data = S(N-1) data. out_valid = S(N-1) valid.
- advance = !(out_valid && !out_ready). in_ready = advance.
- On advance, every stage shifts one position. S0 loads stage-0 exchange of in_data with valid = in_valid. Bubbles propagate as invalid stages and are not collapsed.
- When advance = 0, all stage registers hold.
- Accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- busy = OR of all stage valid bits.

## Timing
- Reset (async assert, sync release): all valid bits 0 and all data/tag registers 0. Therefore out_valid=0, out_data=0, out_rank=0, busy=0, in_ready=1.
- Latency is N cycles. A transaction accepted in cycle c is presented with out_valid=1 in cycle c+N, given no stalls.
- Throughput is one transaction per cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 hold every stage, and in_ready=0 in the same cycle (combinational). Outputs stay stable until the transfer completes.
- Output transfer and input accept may occur in the same cycle; the pipeline shifts once.
- in_valid with in_ready=0 is ignored. The source must hold its data, as per the standard valid/ready rule.
- When out_valid=0, in_ready=1 regardless of out_ready. This lets an empty output slot fill.
- rst_n asserted mid-stream discards all in-flight transactions immediately (asynchronous). No output appears after release until new inputs arrive.
- Unpaired lanes: lane N-1 at even stages when N is odd; lane 0 at odd stages. They must pass through unchanged.

## Test plan
- Reset, W=8, N=9: after release, out_valid=0, busy=0, in_ready=1 -> in_data {9,3,7,1,8,2,6,4,5}, rank_sel=4 in cycle c -> cycle c+9: out_data slots 0..8 = 1..9, out_rank=5.
- Streaming, out_ready=1: 20 back-to-back random windows with rank_sel cycling 0,4,8 -> outputs in order on 20 consecutive cycles, each matching a reference sort, out_rank = min/median/max.
- Backpressure: out_ready toggled by a random 50% pattern -> no loss or duplication; out_data is stable while out_valid && !out_ready; in_ready == !(out_valid && !out_ready) every cycle.
- Edge data: all-equal 8'hAA, all-zero, all-0xFF, reverse-sorted input, and rank_sel=15 -> correct order, out_rank = slot 8.
- Parameters: N=2, W=1 with {1,0} -> {0,1}. N=16, W=12, DESC=1 with random data -> descending order, latency 16.
- Reset mid-stream: 5 transactions in flight, assert rst_n=0 for 1 cycle -> out_valid and busy drop at once, and no stale output follows release.
